wb_pass_through_chk: RTL and testbench

//   Synthesisable pass-through checker for pipelined Wishbone links. Compares initiator- and target-side signals.

---
 rtl/wb_pass_through_pkg.sv | 21 ++
 rtl/wb_pass_through_chk_if.sv | 50 +++++
 rtl/wb_pt_queue.sv | 74 +++++++
 rtl/wb_pass_through_chk.sv | 67 ++++++
 tb/tb_wb_pass_through_chk.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_pass_through_pkg.sv
// Shared constants and helpers for the Wishbone pass-through checker.
package wb_pass_through_pkg;

  localparam int unsigned VIOL_CTRL = 0;
  localparam int unsigned VIOL_ADR  = 1;
  localparam int unsigned VIOL_WDAT = 2;
  localparam int unsigned VIOL_RESP = 3;
  localparam int unsigned VIOL_RDAT = 4;
  localparam int unsigned VIOL_MULT = 5;
  localparam int unsigned VIOL_OVF  = 6;
  localparam int unsigned VIOL_SPUR = 7;
  localparam int unsigned VIOL_W    = 8;

  typedef logic [VIOL_W-1:0] viol_t;

  // True when two or more of the three response strobes are high.
  function automatic logic multi_hot3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/wb_pass_through_chk_if.sv
// Observed initiator- and target-side Wishbone bundles of one pass-through link.
interface wb_pass_through_chk_if #(
  parameter int unsigned ADR_WIDTH  = 16,
  parameter int unsigned DAT_WIDTH  = 16,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned TGA_WIDTH  = 1,
  parameter int unsigned TGC_WIDTH  = 1,
  parameter int unsigned TGRD_WIDTH = 1,
  parameter int unsigned TGWD_WIDTH = 1
);
  logic                  itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i;
  logic [SEL_WIDTH-1:0]  itr_sel_i;
  logic [ADR_WIDTH-1:0]  itr_adr_i;
  logic [DAT_WIDTH-1:0]  itr_dat_i;
  logic [TGA_WIDTH-1:0]  itr_tga_i;
  logic [TGC_WIDTH-1:0]  itr_tgc_i;
  logic [TGWD_WIDTH-1:0] itr_tgd_i;
  logic                  itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o;
  logic [DAT_WIDTH-1:0]  itr_dat_o;
  logic [TGRD_WIDTH-1:0] itr_tgd_o;

  logic                  tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o;
  logic [SEL_WIDTH-1:0]  tgt_sel_o;
  logic [ADR_WIDTH-1:0]  tgt_adr_o;
  logic [DAT_WIDTH-1:0]  tgt_dat_o;
  logic [TGA_WIDTH-1:0]  tgt_tga_o;
  logic [TGC_WIDTH-1:0]  tgt_tgc_o;
  logic [TGWD_WIDTH-1:0] tgt_tgd_o;
  logic                  tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i;
  logic [DAT_WIDTH-1:0]  tgt_dat_i;
  logic [TGRD_WIDTH-1:0] tgt_tgd_i;

  // master: whatever drives the link; slave: the passive checker.
  modport master (
    output itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i, itr_sel_i, itr_adr_i, itr_dat_i,
           itr_tga_i, itr_tgc_i, itr_tgd_i, itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o,
           itr_dat_o, itr_tgd_o,
           tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o, tgt_sel_o, tgt_adr_o, tgt_dat_o,
           tgt_tga_o, tgt_tgc_o, tgt_tgd_o, tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i,
           tgt_dat_i, tgt_tgd_i
  );
  modport slave (
    input  itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i, itr_sel_i, itr_adr_i, itr_dat_i,
           itr_tga_i, itr_tgc_i, itr_tgd_i, itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o,
           itr_dat_o, itr_tgd_o,
           tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o, tgt_sel_o, tgt_adr_o, tgt_dat_o,
           tgt_tga_o, tgt_tgc_o, tgt_tgd_o, tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i,
           tgt_dat_i, tgt_tgd_i
  );
endinterface

// File: rtl/wb_pt_queue.sv
// In-order DEPTH x 1 FIFO remembering the we bit of each outstanding access.
module wb_pt_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         async_rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic                         we_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         head_we_o,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             do_push, do_pop;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign head_we_o = mem_q[rd_ptr_q];
  assign busy_o    = busy_q;
  assign count_o   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = we_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    busy_d = (count_d != '0);
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: rtl/wb_pass_through_chk.sv
// Compares both sides of a one-to-one Wishbone pass-through and keeps sticky violation flags.
module wb_pass_through_chk
  import wb_pass_through_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       async_rst_i,
  input  logic                       chk_en_i,
  input  logic                       clr_i,
  wb_pass_through_chk_if.slave       wb,
  output viol_t                      viol_o,
  output logic [$clog2(DEPTH+1)-1:0] pend_cnt_o,
  output logic                       busy_o
);
  viol_t viol_q, viol_d, viol_new;
  logic  req, ack, flush, full, empty, head_we;

  wb_pt_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .push_i      (req),
    .pop_i       (ack),
    .flush_i     (flush),
    .we_i        (wb.itr_we_i),
    .full_o      (full),
    .empty_o     (empty),
    .head_we_o   (head_we),
    .busy_o      (busy_o),
    .count_o     (pend_cnt_o)
  );

  // All checks look at the queue before this cycle's push.
  always_comb begin
    viol_new = '0;
    req   = chk_en_i & wb.itr_cyc_i & wb.itr_stb_i & ~wb.itr_stall_o;
    ack   = wb.itr_ack_o | wb.itr_err_o | wb.itr_rty_o;
    flush = ~wb.itr_cyc_i;

    viol_new[VIOL_CTRL] = chk_en_i & ((wb.tgt_cyc_o != wb.itr_cyc_i) |
                                      (wb.tgt_stb_o != wb.itr_stb_i) |
                                      (wb.itr_stall_o != wb.tgt_stall_i));
    viol_new[VIOL_ADR]  = req & ((wb.tgt_we_o != wb.itr_we_i) | (wb.tgt_lock_o != wb.itr_lock_i) |
                                 (wb.tgt_sel_o != wb.itr_sel_i) | (wb.tgt_adr_o != wb.itr_adr_i) |
                                 (wb.tgt_tga_o != wb.itr_tga_i) | (wb.tgt_tgc_o != wb.itr_tgc_i));
    viol_new[VIOL_WDAT] = req & wb.itr_we_i & ((wb.tgt_dat_o != wb.itr_dat_i) |
                                               (wb.tgt_tgd_o != wb.itr_tgd_i));
    viol_new[VIOL_RESP] = chk_en_i & ~empty & ((wb.itr_ack_o != wb.tgt_ack_i) |
                                               (wb.itr_err_o != wb.tgt_err_i) |
                                               (wb.itr_rty_o != wb.tgt_rty_i));
    viol_new[VIOL_RDAT] = chk_en_i & ack & ~empty & ~head_we &
                          ((wb.itr_dat_o != wb.tgt_dat_i) | (wb.itr_tgd_o != wb.tgt_tgd_i));
    viol_new[VIOL_MULT] = chk_en_i & multi_hot3(wb.itr_ack_o, wb.itr_err_o, wb.itr_rty_o);
    viol_new[VIOL_OVF]  = req & full & ~(ack & ~empty);
    viol_new[VIOL_SPUR] = chk_en_i & ack & empty;

    // A fresh violation wins over a simultaneous clear.
    viol_d = (clr_i ? '0 : viol_q) | viol_new;
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) viol_q <= '0;
    else             viol_q <= viol_d;
  end

  assign viol_o = viol_q;
endmodule

// File: tb/tb_wb_pass_through_chk.sv
// Directed bench for wb_pass_through_chk: vector table plus multi-cycle corner sequences.
module tb_wb_pass_through_chk;
  import wb_pass_through_pkg::*;

  logic       clk_i = 1'b0;
  logic       async_rst_i = 1'b0;
  logic       chk_en_i = 1'b1;
  logic       clr_i = 1'b0;
  logic [7:0] viol_o;
  logic [2:0] pend_cnt_o;
  logic       busy_o;
  int         total = 0;
  int         bad = 0;

  localparam logic [7:0] F_CTRL = 8'h01;
  localparam logic [7:0] F_ADR  = 8'h02;
  localparam logic [7:0] F_WDAT = 8'h04;
  localparam logic [7:0] F_RESP = 8'h08;
  localparam logic [7:0] F_RDAT = 8'h10;
  localparam logic [7:0] F_MULT = 8'h20;
  localparam logic [7:0] F_OVF  = 8'h40;
  localparam logic [7:0] F_SPUR = 8'h80;

  wb_pass_through_chk_if bus ();

  wb_pass_through_chk #(.DEPTH(4)) dut (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .chk_en_i    (chk_en_i),
    .clr_i       (clr_i),
    .wb          (bus.slave),
    .viol_o      (viol_o),
    .pend_cnt_o  (pend_cnt_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        cyc, stb, we, ack, clr;
    logic [15:0] adr, wdat, rdat_i, rdat_t;
    logic [2:0]  exp_cnt;
    logic [7:0]  exp_viol;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic cyc, stb, we, ack, clr,
                              input logic [15:0] adr, wdat, rdat_i, rdat_t,
                              input logic [2:0] cnt, input logic [7:0] viol);
    vec_t v;
    v.name = name; v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack; v.clr = clr;
    v.adr = adr; v.wdat = wdat; v.rdat_i = rdat_i; v.rdat_t = rdat_t;
    v.exp_cnt = cnt; v.exp_viol = viol;
    return v;
  endfunction

  // Drive the initiator side and mirror it exactly onto the target side.
  task automatic set_bus(input logic cyc, stb, we, ack, err, input logic [15:0] adr, wdat, rdat);
    bus.itr_cyc_i = cyc;  bus.itr_stb_i = stb;  bus.itr_we_i = we;  bus.itr_lock_i = 1'b0;
    bus.itr_sel_i = 2'b11; bus.itr_adr_i = adr; bus.itr_dat_i = wdat;
    bus.itr_tga_i = 1'b0; bus.itr_tgc_i = 1'b0; bus.itr_tgd_i = 1'b0;
    bus.itr_ack_o = ack;  bus.itr_err_o = err;  bus.itr_rty_o = 1'b0; bus.itr_stall_o = 1'b0;
    bus.itr_dat_o = rdat; bus.itr_tgd_o = 1'b0;
    bus.tgt_cyc_o = cyc;  bus.tgt_stb_o = stb;  bus.tgt_we_o = we;  bus.tgt_lock_o = 1'b0;
    bus.tgt_sel_o = 2'b11; bus.tgt_adr_o = adr; bus.tgt_dat_o = wdat;
    bus.tgt_tga_o = 1'b0; bus.tgt_tgc_o = 1'b0; bus.tgt_tgd_o = 1'b0;
    bus.tgt_ack_i = ack;  bus.tgt_err_i = err;  bus.tgt_rty_i = 1'b0; bus.tgt_stall_i = 1'b0;
    bus.tgt_dat_i = rdat; bus.tgt_tgd_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] cnt, input logic [7:0] viol);
    total++;
    if (pend_cnt_o !== cnt) begin
      bad++;
      $display("FAIL %s cnt: got %0d want %0d", name, pend_cnt_o, cnt);
    end
    total++;
    if (viol_o !== viol) begin
      bad++;
      $display("FAIL %s viol: got %h want %h", name, viol_o, viol);
    end
    total++;
    if (busy_o !== (cnt != 3'd0)) begin
      bad++;
      $display("FAIL %s busy: got %b want %b", name, busy_o, (cnt != 3'd0));
    end
  endtask

  task automatic idle_clear();
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  initial begin
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    #1 async_rst_i = 1'b1;
    #1 check("reset", 3'd0, 8'h00);
    @(posedge clk_i);
    #1 async_rst_i = 1'b0;

    // Single write, then four reads with a corrupted third read-data beat.
    vecs.push_back(mk("idle",   0,0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 8'h00));
    vecs.push_back(mk("wr_req", 1,1,1,0,0, 16'h0010, 16'h1234, 16'h0000, 16'h0000, 3'd1, 8'h00));
    vecs.push_back(mk("wr_ack", 1,0,0,1,0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 8'h00));
    vecs.push_back(mk("idle2",  0,0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 8'h00));
    vecs.push_back(mk("rd0",    1,1,0,0,0, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 3'd1, 8'h00));
    vecs.push_back(mk("rd1",    1,1,0,0,0, 16'h0021, 16'h0000, 16'h0000, 16'h0000, 3'd2, 8'h00));
    vecs.push_back(mk("rd2",    1,1,0,0,0, 16'h0022, 16'h0000, 16'h0000, 16'h0000, 3'd3, 8'h00));
    vecs.push_back(mk("rd3",    1,1,0,0,0, 16'h0023, 16'h0000, 16'h0000, 16'h0000, 3'd4, 8'h00));
    vecs.push_back(mk("ack0",   1,0,0,1,0, 16'h0000, 16'h0000, 16'h1111, 16'h1111, 3'd3, 8'h00));
    vecs.push_back(mk("ack1",   1,0,0,1,0, 16'h0000, 16'h0000, 16'h2222, 16'h2222, 3'd2, 8'h00));
    vecs.push_back(mk("ack2",   1,0,0,1,0, 16'h0000, 16'h0000, 16'hBEEE, 16'hBEEF, 3'd1, F_RDAT));
    vecs.push_back(mk("ack3",   1,0,0,1,0, 16'h0000, 16'h0000, 16'h4444, 16'h4444, 3'd0, F_RDAT));
    vecs.push_back(mk("clr",    0,0,0,0,1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 8'h00));

    foreach (vecs[i]) begin
      set_bus(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].ack, 1'b0,
              vecs[i].adr, vecs[i].wdat, vecs[i].rdat_i);
      bus.tgt_dat_i = vecs[i].rdat_t;
      clr_i = vecs[i].clr;
      tick();
      check(vecs[i].name, vecs[i].exp_cnt, vecs[i].exp_viol);
    end
    clr_i = 1'b0;

    // Five pipelined reads into a depth-4 queue, then drain.
    for (int i = 0; i < 5; i++) begin
      set_bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0040 + i), 16'h0, 16'h0);
      tick();
      if (i == 3) check("ovf_fill", 3'd4, 8'h00);
    end
    check("ovf_set", 3'd4, F_OVF);
    for (int i = 0; i < 4; i++) begin
      set_bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h5555);
      tick();
    end
    check("ovf_drain", 3'd0, F_OVF);
    idle_clear();
    check("ovf_clr", 3'd0, 8'h00);

    // Ack while idle, then ack+err together, then clear.
    set_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    tick();
    check("spur_idle", 3'd0, F_SPUR);
    set_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);
    tick();
    check("mult", 3'd0, F_SPUR | F_MULT);
    idle_clear();
    check("mult_clr", 3'd0, 8'h00);

    // Abort with two reads outstanding, then a late ack.
    for (int i = 0; i < 2; i++) begin
      set_bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0060 + i), 16'h0, 16'h0);
      tick();
    end
    check("abort_pend", 3'd2, 8'h00);
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    tick();
    check("abort_flush", 3'd0, 8'h00);
    set_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    tick();
    check("late_ack", 3'd0, F_SPUR);
    idle_clear();

    // Stall mismatch sets CTRL and blocks the push.
    set_bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0070, 16'h0, 16'h0);
    bus.itr_stall_o = 1'b1;
    tick();
    check("ctrl", 3'd0, F_CTRL);
    idle_clear();

    // Corrupted write data, then a response mismatch on its ack.
    set_bus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0080, 16'hA5A5, 16'h0);
    bus.tgt_dat_o = 16'hA5A4;
    tick();
    check("wdat", 3'd1, F_WDAT);
    set_bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    bus.tgt_ack_i = 1'b0;
    tick();
    check("resp", 3'd0, F_WDAT | F_RESP);
    idle_clear();

    // Checker disabled: no push and no flag despite an address mismatch.
    chk_en_i = 1'b0;
    set_bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0090, 16'h0, 16'h0);
    bus.tgt_adr_o = 16'h0091;
    tick();
    check("disabled", 3'd0, 8'h00);
    chk_en_i = 1'b1;
    idle_clear();

    // Async reset mid-burst with three pending and a flag set.
    for (int i = 0; i < 3; i++) begin
      set_bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h00A0 + i), 16'h0, 16'h0);
      if (i == 2) bus.tgt_adr_o = 16'h00A3;
      tick();
    end
    check("pre_rst", 3'd3, F_ADR);
    #2 async_rst_i = 1'b1;
    #1 check("async_rst", 3'd0, 8'h00);
    #1 async_rst_i = 1'b0;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    tick();
    check("post_rst", 3'd0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
